// File: rtl/uart_receiver.sv
// 8N1 UART receiver driven by an oversampled clock-enable tick.
// It recovers bytes from the serial line and presents them with ready, frame-error and overrun flags.
module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       Rx,
    input  logic       clken,
    input  logic       rdy_clr,
    output logic [7:0] data_out,
    output logic       rdy,
    output logic       frame_err,
    output logic       overrun,
    output logic       Rx_busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic          r_rx_meta, r_rx_s;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_bit_pos, w_bit_pos_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [7:0]    r_data;
    logic          r_rdy, r_ferr, r_ovr;
    logic          w_rx_s, w_byte_ok, w_frame_bad;

    assign w_rx_s = r_rx_s;

    // Both flops reset high so reset never looks like a start bit.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= Rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_pos <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_pos <= w_bit_pos_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_pos_nxt = r_bit_pos;
        w_shift_nxt   = r_shift;
        w_byte_ok     = 1'b0;
        w_frame_bad   = 1'b0;
        if (clken) begin
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        w_state_nxt = START;
                        w_cnt_nxt   = '0;
                    end
                end
                START: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == HALF_M1) begin
                        // A start bit that is high again at its midpoint is a glitch.
                        if (w_rx_s) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt   = DATA;
                            w_cnt_nxt     = '0;
                            w_bit_pos_nxt = '0;
                        end
                    end
                end
                DATA: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == FULL_M1) begin
                        w_shift_nxt[r_bit_pos] = w_rx_s;
                        w_cnt_nxt              = '0;
                        w_bit_pos_nxt          = r_bit_pos + 1'b1;
                        if (r_bit_pos == 3'd7)
                            w_state_nxt = STOP;
                    end
                end
                STOP: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == FULL_M1) begin
                        w_state_nxt = IDLE;
                        w_byte_ok   = w_rx_s;
                        w_frame_bad = !w_rx_s;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Clear first, then set, so a completing frame wins over a same-cycle acknowledge.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= 8'h00;
            r_rdy  <= 1'b0;
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (rdy_clr) begin
                r_rdy  <= 1'b0;
                r_ferr <= 1'b0;
                r_ovr  <= 1'b0;
            end
            if (w_byte_ok) begin
                r_data <= r_shift;
                r_rdy  <= 1'b1;
                if (r_rdy)
                    r_ovr <= 1'b1;
            end
            if (w_frame_bad)
                r_ferr <= 1'b1;
        end
    end

    assign data_out  = r_data;
    assign rdy       = r_rdy;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;
    assign Rx_busy   = (r_state != IDLE);

endmodule
